// File: rtl/ucode_pipeline_pkg.sv
// Shared definitions for the microprogram pipeline: microword field positions,
// condition-select codes, the reset microword and the interrupt vector encoding.
package ucode_pkg;

   localparam int I_LSB     = 0;
   localparam int BR_LSB    = 4;
   localparam int CCEN_BIT  = 8;
   localparam int CSEL_LSB  = 9;
   localparam int CPOL_BIT  = 12;
   localparam int CI_BIT    = 13;
   localparam int RLD_BIT   = 14;
   localparam int OPSTB_BIT = 15;
   localparam int IACK_BIT  = 16;
   localparam int CTRL_LSB  = 17;

   typedef enum logic [2:0] {
      CSEL_S0   = 3'd0,
      CSEL_S1   = 3'd1,
      CSEL_S2   = 3'd2,
      CSEL_S3   = 3'd3,
      CSEL_S4   = 3'd4,
      CSEL_IRQ  = 3'd5,
      CSEL_FULL = 3'd6,
      CSEL_ONE  = 3'd7
   } csel_e;

   // JZ with carry-in, register load and the condition test forced to pass.
   localparam logic [31:0] RESET_WORD = (32'd1 << CI_BIT) | (32'd1 << RLD_BIT) | (32'd1 << CCEN_BIT);

   localparam logic [3:0] VEC_BASE = 4'b1000;

   function automatic logic [3:0] vec_of(input logic [1:0] idx);
      return VEC_BASE | {1'b0, idx, 1'b0};
   endfunction

endpackage

// File: rtl/ucode_pipeline_irq_prioritizer.sv
// Interrupt edge capture, pending register and highest-priority vector encode.
module irq_prioritizer
   import ucode_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] irq,
   input  logic       iack,
   input  logic       vect,   // active low: the vector is frozen while the sequencer reads it
   output logic [3:0] pend,
   output logic [3:0] vecreg
);

   logic [3:0] prev;
   logic [3:0] edges;
   logic [3:0] clr;
   logic [3:0] pend_next;
   logic [3:0] vec_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      edges = irq & ~prev;
      clr   = '0;
      if (iack && vecreg[3]) clr[vecreg[2:1]] = 1'b1;
      // A fresh edge is OR-ed in after the clear so it survives an acknowledge.
      pend_next = (pend & ~clr) | edges;
      vec_next  = '0;
      for (int k = 0; k < 4; k++) begin
         if (pend_next[k]) vec_next = vec_of(2'(k));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev   <= '0;
         pend   <= '0;
         vecreg <= '0;
      end else begin
         prev <= irq;
         pend <= pend_next;
         if (vect) vecreg <= vec_next;
      end
   end

endmodule

// File: rtl/ucode_pipeline.sv
// Microprogram pipeline register with sequencer glue: D-bus source mux,
// condition select, one-entry macro-opcode map buffer and interrupt vectoring.
module ucode_pipeline
   import ucode_pkg::*;
#(
   parameter int CTRL_W = 15
) (
   input  logic              CP,
   input  logic              RESET,
   input  logic [11:0]       Y,
   input  logic              PL,
   input  logic              MAP,
   input  logic              VECT,
   output logic [11:0]       ROM_ADDR,
   input  logic [31:0]       ROM_DATA,
   output logic [3:0]        I,
   output logic [3:0]        D_OUT,
   output logic              CC,
   output logic              CCEN,
   output logic              RLD,
   output logic              CI,
   input  logic              OP_VALID,
   input  logic [3:0]        OP_CODE,
   output logic              OP_READY,
   input  logic [3:0]        IRQ,
   input  logic [4:0]        STATUS,
   output logic [CTRL_W-1:0] CTRL,
   output logic              ERR_UNDERRUN
);

   logic [31:0] pipe;
   logic [4:0]  stat;
   logic [3:0]  mapreg;
   logic        full;
   logic [3:0]  pend;
   logic [3:0]  vecreg;
   logic [3:0]  br;
   csel_e       csel;
   logic        cpol;
   logic        opstb;
   logic        iack;
   logic        load;
   logic        selected;

   assign ROM_ADDR = Y;

   assign I     = pipe[I_LSB +: 4];
   assign br    = pipe[BR_LSB +: 4];
   assign CCEN  = pipe[CCEN_BIT];
   assign csel  = csel_e'(pipe[CSEL_LSB +: 3]);
   assign cpol  = pipe[CPOL_BIT];
   assign CI    = pipe[CI_BIT];
   assign RLD   = pipe[RLD_BIT];
   assign opstb = pipe[OPSTB_BIT];
   assign iack  = pipe[IACK_BIT];
   assign CTRL  = pipe[CTRL_LSB +: CTRL_W];

   always_ff @(posedge CP) begin
      if (RESET) begin
         pipe <= RESET_WORD;
         stat <= '0;
      end else begin
         pipe <= ROM_DATA;
         stat <= STATUS;
      end
   end

   assign OP_READY = ~full | opstb;
   assign load     = OP_VALID & OP_READY;

   // Reset takes priority, so an opcode offered in the reset cycle is dropped.
   always_ff @(posedge CP) begin
      if (RESET) begin
         full         <= 1'b0;
         mapreg       <= '0;
         ERR_UNDERRUN <= 1'b0;
      end else begin
         if (load) begin
            mapreg <= OP_CODE;
            full   <= 1'b1;
         end else if (opstb) begin
            full <= 1'b0;
         end
         if (opstb && !full) ERR_UNDERRUN <= 1'b1;
      end
   end

   irq_prioritizer u_irq (
      .clk    (CP),
      .rst    (RESET),
      .irq    (IRQ),
      .iack   (iack),
      .vect   (VECT),
      .pend   (pend),
      .vecreg (vecreg)
   );

   always_comb begin
      if (!PL)        D_OUT = br;
      else if (!MAP)  D_OUT = mapreg;
      else if (!VECT) D_OUT = vecreg;
      else            D_OUT = 4'h0;
   end

   always_comb begin
      unique case (csel)
         CSEL_IRQ:  selected = |pend;
         CSEL_FULL: selected = full;
         CSEL_ONE:  selected = 1'b1;
         default:   selected = stat[csel];
      endcase
   end

   // The sequencer's CC input is active low: low means the test passed.
   assign CC = ~(selected ^ cpol);

endmodule

// File: tb/tb_ucode_pipeline.sv
// Directed bench for ucode_pipeline: a decode/condition vector table followed by
// hand-written map-buffer, interrupt and reset sequences.
module tb_ucode_pipeline;

   logic        CP = 1'b0;
   logic        RESET;
   logic [11:0] Y;
   logic        PL, MAP, VECT;
   logic [11:0] ROM_ADDR;
   logic [31:0] ROM_DATA;
   logic [3:0]  I, D_OUT;
   logic        CC, CCEN, RLD, CI;
   logic        OP_VALID;
   logic [3:0]  OP_CODE;
   logic        OP_READY;
   logic [3:0]  IRQ;
   logic [4:0]  STATUS;
   logic [14:0] CTRL;
   logic        ERR_UNDERRUN;

   int n_pass  = 0;
   int n_total = 0;

   ucode_pipeline #(.CTRL_W(15)) dut (
      .CP(CP), .RESET(RESET), .Y(Y), .PL(PL), .MAP(MAP), .VECT(VECT),
      .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .I(I), .D_OUT(D_OUT),
      .CC(CC), .CCEN(CCEN), .RLD(RLD), .CI(CI), .OP_VALID(OP_VALID),
      .OP_CODE(OP_CODE), .OP_READY(OP_READY), .IRQ(IRQ), .STATUS(STATUS),
      .CTRL(CTRL), .ERR_UNDERRUN(ERR_UNDERRUN)
   );

   always #5 CP = ~CP;

   typedef struct {
      logic [31:0] rom;
      logic [4:0]  status;
      logic        pl, map, vect;
      logic [3:0]  i, d_out;
      logic        cc;
      logic [2:0]  flags;   // {ccen, ci, rld}
      logic [14:0] ctrl;
   } vec_t;

   vec_t tbl [8];

   // Microword built from independent field values.
   function automatic logic [31:0] uw(input logic [3:0] i, input logic [3:0] br,
                                      input logic ccen, input logic [2:0] csel,
                                      input logic cpol, input logic ci, input logic rld,
                                      input logic opstb, input logic iack,
                                      input logic [14:0] ctrl);
      return {ctrl, iack, opstb, rld, ci, cpol, csel, ccen, br, i};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   task automatic peek_dout(input string name, input logic pl, input logic map,
                            input logic vect, input logic [3:0] exp);
      PL = pl; MAP = map; VECT = vect;
      #1;
      check(name, D_OUT, exp);
      PL = 1'b1; MAP = 1'b1; VECT = 1'b1;
      #1;
   endtask

   initial begin
      logic [31:0] w_strobe, w_iack, w_sel5, w_sel6, w_sel6n;
      w_strobe = uw(4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0);
      w_iack   = uw(4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0);
      w_sel5   = uw(4'h0, 4'h0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
      w_sel6   = uw(4'h0, 4'h0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
      w_sel6n  = uw(4'h0, 4'h0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);

      //            rom                                                                  status    pl    map   vect  i     d_out cc    flags   ctrl
      tbl[0] = '{uw(4'hA,4'h5,1'b0,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0,15'h0000), 5'b00100, 1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 3'b000, 15'h0000};
      tbl[1] = '{uw(4'hA,4'h5,1'b0,3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,15'h0000), 5'b00100, 1'b1, 1'b1, 1'b1, 4'hA, 4'h0, 1'b1, 3'b000, 15'h0000};
      tbl[2] = '{uw(4'hF,4'h3,1'b1,3'd7,1'b0,1'b1,1'b1,1'b0,1'b0,15'h7FFF), 5'b00000, 1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 1'b0, 3'b111, 15'h7FFF};
      tbl[3] = '{uw(4'h1,4'hC,1'b0,3'd0,1'b0,1'b0,1'b1,1'b0,1'b0,15'h1234), 5'b00001, 1'b1, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 3'b001, 15'h1234};
      tbl[4] = '{uw(4'h2,4'h0,1'b0,3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,15'h0001), 5'b01111, 1'b1, 1'b1, 1'b1, 4'h2, 4'h0, 1'b1, 3'b000, 15'h0001};
      tbl[5] = '{uw(4'h3,4'h6,1'b1,3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,15'h4000), 5'b11111, 1'b1, 1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 3'b100, 15'h4000};
      tbl[6] = '{uw(4'h4,4'h9,1'b0,3'd6,1'b1,1'b1,1'b0,1'b0,1'b0,15'h0000), 5'b00000, 1'b1, 1'b1, 1'b0, 4'h4, 4'h0, 1'b0, 3'b010, 15'h0000};
      tbl[7] = '{uw(4'h5,4'hE,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0,1'b0,15'h2AAA), 5'b10111, 1'b0, 1'b1, 1'b1, 4'h5, 4'hE, 1'b0, 3'b000, 15'h2AAA};

      RESET = 1'b1; Y = 12'h000; PL = 1'b1; MAP = 1'b1; VECT = 1'b1;
      ROM_DATA = '0; OP_VALID = 1'b0; OP_CODE = '0; IRQ = '0; STATUS = '0;

      // Reset state, observed in the first cycle after the last reset edge.
      step(); step();
      RESET = 1'b0;
      check("rst_i",     I, 4'h0);
      check("rst_flags", {CCEN, CI, RLD}, 3'b111);
      check("rst_dout",  D_OUT, 4'h0);
      check("rst_ready", OP_READY, 1'b1);
      check("rst_ctrl",  CTRL, 15'h0);
      check("rst_err",   ERR_UNDERRUN, 1'b0);
      Y = 12'hA5C;
      #1 check("rom_addr", ROM_ADDR, 12'hA5C);

      // Field decode, D-bus priority and condition select.
      for (int k = 0; k < 8; k++) begin
         ROM_DATA = tbl[k].rom; STATUS = tbl[k].status;
         PL = tbl[k].pl; MAP = tbl[k].map; VECT = tbl[k].vect;
         step();
         check($sformatf("v%0d_i", k),     I, tbl[k].i);
         check($sformatf("v%0d_dout", k),  D_OUT, tbl[k].d_out);
         check($sformatf("v%0d_cc", k),    CC, tbl[k].cc);
         check($sformatf("v%0d_flags", k), {CCEN, CI, RLD}, tbl[k].flags);
         check($sformatf("v%0d_ctrl", k),  CTRL, tbl[k].ctrl);
      end
      PL = 1'b1; MAP = 1'b1; VECT = 1'b1; STATUS = '0;

      // D-bus sources: BR, then MAPREG, then nothing.
      OP_VALID = 1'b1; OP_CODE = 4'h9;
      ROM_DATA = uw(4'h0, 4'h5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0);
      step();
      OP_VALID = 1'b0;
      check("map9_ready", OP_READY, 1'b0);
      peek_dout("dsrc_br",  1'b0, 1'b1, 1'b1, 4'h5);
      peek_dout("dsrc_map", 1'b1, 1'b0, 1'b1, 4'h9);
      peek_dout("dsrc_none", 1'b1, 1'b1, 1'b1, 4'h0);
      ROM_DATA = w_strobe; step();
      check("strobe_ready", OP_READY, 1'b1);
      ROM_DATA = '0; step();
      check("drain_ready", OP_READY, 1'b1);
      check("drain_err",   ERR_UNDERRUN, 1'b0);

      // Map buffer: accept, simultaneous strobe+load, drain, underrun.
      OP_VALID = 1'b1; OP_CODE = 4'h3; ROM_DATA = w_sel6; step();
      OP_VALID = 1'b0;
      check("op3_full_cc", CC, 1'b0);
      check("op3_ready",   OP_READY, 1'b0);
      peek_dout("op3_map", 1'b1, 1'b0, 1'b1, 4'h3);
      ROM_DATA = w_strobe; step();
      check("op3_strobe_ready", OP_READY, 1'b1);
      OP_VALID = 1'b1; OP_CODE = 4'h7; ROM_DATA = w_sel6; step();
      OP_VALID = 1'b0;
      check("op7_full_cc", CC, 1'b0);
      check("op7_ready",   OP_READY, 1'b0);
      peek_dout("op7_map", 1'b1, 1'b0, 1'b1, 4'h7);
      ROM_DATA = w_strobe; step();
      ROM_DATA = w_sel6; step();
      check("empty_cc",  CC, 1'b1);
      check("empty_err", ERR_UNDERRUN, 1'b0);
      ROM_DATA = w_strobe; step();
      check("under_pre_err", ERR_UNDERRUN, 1'b0);
      ROM_DATA = '0; step();
      check("under_err", ERR_UNDERRUN, 1'b1);
      peek_dout("under_map_hold", 1'b1, 1'b0, 1'b1, 4'h7);
      step();
      check("under_sticky", ERR_UNDERRUN, 1'b1);

      // Interrupts: two simultaneous edges, then acknowledge each in turn.
      IRQ = 4'b1010; ROM_DATA = w_sel5; step();
      check("irq_pend_cc", CC, 1'b0);
      peek_dout("irq_vec_e", 1'b1, 1'b1, 1'b0, 4'hE);
      ROM_DATA = w_iack; step();
      ROM_DATA = '0; step();
      peek_dout("irq_vec_a", 1'b1, 1'b1, 1'b0, 4'hA);
      ROM_DATA = w_iack; step();
      ROM_DATA = w_sel5; step();
      check("irq_none_cc", CC, 1'b1);
      peek_dout("irq_vec_0", 1'b1, 1'b1, 1'b0, 4'h0);

      // A new edge on the acknowledged bit wins over the clear.
      IRQ = 4'b0000; ROM_DATA = '0; step();
      IRQ = 4'b0100; step();
      peek_dout("irq_vec_c", 1'b1, 1'b1, 1'b0, 4'hC);
      IRQ = 4'b0000; ROM_DATA = w_iack; step();
      IRQ = 4'b0100; ROM_DATA = w_sel5; step();
      check("race_cc", CC, 1'b0);
      peek_dout("race_vec_c", 1'b1, 1'b1, 1'b0, 4'hC);

      // Reset while the buffer is full, a handshake is offered and bit 2 pends.
      OP_VALID = 1'b1; OP_CODE = 4'h5; ROM_DATA = w_strobe; step();
      check("pre_rst_ready", OP_READY, 1'b1);
      RESET = 1'b1; OP_CODE = 4'h6; IRQ = 4'b0000; ROM_DATA = '0; step();
      RESET = 1'b0; OP_VALID = 1'b0;
      check("mid_rst_ready", OP_READY, 1'b1);
      check("mid_rst_word",  {CTRL, CCEN, CI, RLD, I}, {15'h0, 3'b111, 4'h0});
      check("mid_rst_err",   ERR_UNDERRUN, 1'b0);
      peek_dout("mid_rst_map", 1'b1, 1'b0, 1'b1, 4'h0);
      peek_dout("mid_rst_vec", 1'b1, 1'b1, 1'b0, 4'h0);
      ROM_DATA = w_sel6n; step();
      check("mid_rst_empty_cc", CC, 1'b0);
      ROM_DATA = w_sel5; step();
      check("mid_rst_nopend_cc", CC, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
